// File: rtl/mac_tx_pkg.sv
// Shared definitions for the MAC transmit byte generator: state encodings,
// header geometry and the default station addresses.
package mac_tx_pkg;

    typedef enum logic [7:0] {
        IDLE = 8'h00,
        WAIT = 8'h01,
        DONE = 8'h03,
        HEAD = 8'h10,
        DATA = 8'h20,
        PAD  = 8'h30
    } mac_state_t;

    localparam int HDR_LEN     = 14;
    localparam int MIN_PAYLOAD = 46;

    localparam logic [47:0] DEF_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] DEF_SRC_MAC  = 48'h00_0A_35_01_02_03;
    localparam logic [15:0] DEF_ETH_TYPE = 16'h0800;

endpackage

// File: rtl/mac_hdr_mux.sv
// Combinational select of one Ethernet header byte (destination MAC, source MAC,
// EtherType, most significant byte first) indexed by the header counter.
module mac_hdr_mux
    import mac_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = DEF_DST_MAC,
    parameter logic [47:0] SRC_MAC  = DEF_SRC_MAC,
    parameter logic [15:0] ETH_TYPE = DEF_ETH_TYPE
) (
    input  logic [3:0] hcnt,
    output logic [7:0] hdr_byte
);

    always_comb begin
        hdr_byte = 8'h00;
        case (hcnt)
            4'd0:    hdr_byte = DST_MAC[47:40];
            4'd1:    hdr_byte = DST_MAC[39:32];
            4'd2:    hdr_byte = DST_MAC[31:24];
            4'd3:    hdr_byte = DST_MAC[23:16];
            4'd4:    hdr_byte = DST_MAC[15:8];
            4'd5:    hdr_byte = DST_MAC[7:0];
            4'd6:    hdr_byte = SRC_MAC[47:40];
            4'd7:    hdr_byte = SRC_MAC[39:32];
            4'd8:    hdr_byte = SRC_MAC[31:24];
            4'd9:    hdr_byte = SRC_MAC[23:16];
            4'd10:   hdr_byte = SRC_MAC[15:8];
            4'd11:   hdr_byte = SRC_MAC[7:0];
            4'd12:   hdr_byte = ETH_TYPE[15:8];
            4'd13:   hdr_byte = ETH_TYPE[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/mac_tx.sv
// Ethernet MAC header + payload byte generator feeding the frame transmitter.
// Define MAC_TX_PAD_EN to zero-pad payloads shorter than the 46-byte minimum.
module mac_tx
    import mac_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = DEF_DST_MAC,
    parameter logic [47:0] SRC_MAC  = DEF_SRC_MAC,
    parameter logic [15:0] ETH_TYPE = DEF_ETH_TYPE,
    parameter int          ADDR_W   = 11,
    parameter int          MAX_LEN  = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_mac,
    output logic              fd_mac,
    output logic [7:0]        mac_txd,
    input  logic [15:0]       len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_data
);

    mac_state_t  state;
    logic [3:0]  hcnt;
    logic [10:0] dcnt;
    logic [10:0] len_q;
    logic [10:0] len_clamped;
    logic [10:0] last_idx;
    logic        issue_last;
    logic [7:0]  hdr_byte;

    mac_hdr_mux #(
        .DST_MAC  (DST_MAC),
        .SRC_MAC  (SRC_MAC),
        .ETH_TYPE (ETH_TYPE)
    ) u_hdr_mux (
        .hcnt     (hcnt),
        .hdr_byte (hdr_byte)
    );

    // RAM reads run one cycle ahead of mac_txd, so the address stream stops
    // as soon as the last payload address has been presented.
    always_comb begin
        len_clamped = (len > 16'(MAX_LEN)) ? 11'(MAX_LEN) : len[10:0];
        last_idx    = len_q - 11'd1;
        issue_last  = (ram_addr == ADDR_W'(last_idx));
    end

`ifdef MAC_TX_PAD_EN
    logic need_pad;
    assign need_pad = (len_q < 11'(MIN_PAYLOAD));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hcnt      <= 4'd0;
            dcnt      <= 11'd0;
            len_q     <= 11'd0;
            mac_txd   <= 8'h00;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            fd_mac    <= 1'b0;
        end else begin
            fd_mac <= 1'b0;
            case (state)
                IDLE: begin
                    mac_txd   <= 8'h00;
                    ram_rd_en <= 1'b0;
                    state     <= WAIT;
                end

                WAIT: begin
                    mac_txd   <= 8'h00;
                    ram_rd_en <= 1'b0;
                    if (fs_mac) begin
                        len_q    <= len_clamped;
                        ram_addr <= '0;
                        hcnt     <= 4'd0;
                        dcnt     <= 11'd0;
                        state    <= HEAD;
                    end
                end

                HEAD: begin
                    if (!fs_mac) begin
                        mac_txd   <= 8'h00;
                        ram_rd_en <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        mac_txd <= hdr_byte;
                        if (hcnt == 4'd12) begin
                            ram_rd_en <= (len_q != 11'd0);
                        end
                        if (hcnt == 4'd13) begin
                            dcnt <= 11'd0;
                            if (ram_rd_en) begin
                                if (issue_last) ram_rd_en <= 1'b0;
                                else            ram_addr  <= ram_addr + ADDR_W'(1);
                            end
                            if (len_q != 11'd0) begin
                                state <= DATA;
                            end else begin
`ifdef MAC_TX_PAD_EN
                                state <= PAD;
`else
                                state <= DONE;
`endif
                            end
                        end else begin
                            hcnt <= hcnt + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (!fs_mac) begin
                        mac_txd   <= 8'h00;
                        ram_rd_en <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        mac_txd <= ram_data;
                        dcnt    <= dcnt + 11'd1;
                        if (ram_rd_en) begin
                            if (issue_last) ram_rd_en <= 1'b0;
                            else            ram_addr  <= ram_addr + ADDR_W'(1);
                        end
                        if (dcnt == last_idx) begin
`ifdef MAC_TX_PAD_EN
                            state <= need_pad ? PAD : DONE;
`else
                            state <= DONE;
`endif
                        end
                    end
                end

`ifdef MAC_TX_PAD_EN
                // dcnt keeps counting from the payload length up to the minimum.
                PAD: begin
                    mac_txd   <= 8'h00;
                    ram_rd_en <= 1'b0;
                    if (!fs_mac) begin
                        state <= WAIT;
                    end else begin
                        dcnt <= dcnt + 11'd1;
                        if (dcnt == 11'(MIN_PAYLOAD - 1)) state <= DONE;
                    end
                end
`endif

                // fd_mac lags state entry by one cycle so it follows the last byte.
                DONE: begin
                    mac_txd   <= 8'h00;
                    ram_rd_en <= 1'b0;
                    fd_mac    <= fs_mac;
                    if (!fs_mac) state <= WAIT;
                end

                default: begin
                    mac_txd   <= 8'h00;
                    ram_rd_en <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
